dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares the single-port synchronous data memory between two requesters:
//  m0 = pipeline MEM-stage load/store port, m1 = debug/loader port (bench preload, memory dump).
//  Sits between RISC_V_pipeline_top's data-memory interface and the dmem instance.
//  m0 has fixed priority, with an anti-starvation counter that guarantees m1 service.
//  Read responses are returned through a MEM_LAT-deep tagged pipeline.
// PARAMETERS
//  ADDR_W      32  byte-address width
//  DATA_W      32  data width (byte enables = DATA_W/8)
//  MEM_LAT     1   dmem read latency in cycles, legal range 1..4
//  STARVE_MAX  4   max consecutive m0 grants while m1 waits, legal range 1..15
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous active-low reset
//  mX_req     in   1         X=0,1: request valid; addr/we/wdata/be held stable until gnt
//  mX_we      in   1         1 = write, 0 = read
//  mX_addr    in   ADDR_W    byte address, passed to memory unmodified
//  mX_wdata   in   DATA_W    write data
//  mX_be      in   DATA_W/8  byte enables (writes only)
//  mX_gnt     out  1         accept pulse; request consumed this cycle
//  mX_rvalid  out  1         read data valid, MEM_LAT cycles after the read's gnt
//  mX_rdata   out  DATA_W    read data, qualified by mX_rvalid
//  mem_en     out  1         memory access this cycle
//  mem_we     out  1         memory write strobe
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_be     out  DATA_W/8  memory byte enables
//  mem_rdata  in   DATA_W    memory read data, valid MEM_LAT cycles after a read mem_en
// BEHAVIOUR
//  - Reset (async, rst_n=0): starve_cnt=0, tag pipe cleared. All gnt/rvalid/mem_en/mem_we
//    forced 0 while rst_n=0. rdata outputs are don't-care when their rvalid=0.
//  - Arbitration (combinational, same cycle as req):
//      only m0 req                          -> m0_gnt
//      only m1 req                          -> m1_gnt
//      both req, starve_cnt <  STARVE_MAX   -> m0_gnt
//      both req, starve_cnt == STARVE_MAX   -> m1_gnt
//  - At most one gnt per cycle. mem_en = m0_gnt|m1_gnt. mem_we/addr/wdata/be are muxed from the
//    winner. mem_be = all-ones on reads. mem outputs are 0 when idle.
//  - starve_cnt (registered):
//      m0 granted while m1_req=1  -> +1, saturating at STARVE_MAX
//      m1 granted                 -> 0
//      m1_req=0                   -> 0
//  - Fully pipelined: one new access per cycle, no bubbles. Write completes on its gnt cycle
//    and produces no rvalid.
//  - Read tag pipe: {valid,id} shifts every cycle, MEM_LAT stages. At the output stage,
//    mX_rvalid=valid&&(id==X) and mX_rdata=mem_rdata. Responses are strictly in issue order.
//  - Ordering: a read granted the cycle after a write to the same address returns the new data
//    (memory write-first is assumed at dmem). No reordering between requesters.
//  - The requester must not drop req before gnt. Dropping req without gnt is legal only as an
//    abort; no state changes.
//  - rst_n asserted mid-operation: all in-flight reads are discarded, and no rvalid fires after
//    reset release for pre-reset accesses.
// STRUCTURE
//  - riscv_defs.vh: requester ID encodings (ID_CORE=1'b0, ID_DBG=1'b1) and the default
//    MEM_LAT, shared with the pipeline top and benches.
//  - Sub-module rsp_tag_pipe (params DEPTH, ID_W): the {valid,id} shift register with
//    async clear.
//  - Top level holds the arbiter logic, starve_cnt and the request mux.
// TESTING
//  1. m1 writes 32'hABCDE000 @600 (be=4'hF), then m1 reads @600 -> m1_gnt same cycle as each
//     req; m1_rvalid exactly MEM_LAT cycles after the read gnt; rdata=32'hABCDE000;
//     m0_rvalid stays 0.
//  2. MEM_LAT=2: m0 issues back-to-back reads @600, @604 (holding 0xABCDE000, 4100) ->
//     gnt on 2 consecutive cycles; rvalid on 2 consecutive cycles; data in order.
//  3. STARVE_MAX=4, m0 and m1 both req continuously ->
//     grant pattern m0,m0,m0,m0,m1,m0,m0,m0,m0,m1...; never two gnt in one cycle.
//  4. m0 byte write be=4'b0010, data 32'h0000_5A00, to a word holding 32'h11223344 ->
//     readback 32'h11225A44.
//  5. m0 read granted, rst_n pulled low the next cycle for 1 cycle ->
//     no m0_rvalid ever appears for that read; starve_cnt=0 after reset.
//  6. Write @608 by m1 followed next cycle by m0 read @608 -> m0_rdata equals the m1 write data.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// rtl/dmem_port_arbiter_pkg.sv - shared encodings and helpers for the data-memory port arbiter
package dmem_port_arbiter_pkg;

  // Requester identities carried through the read tag pipe
  localparam logic ID_CORE = 1'b0;
  localparam logic ID_DBG  = 1'b1;

  // Defaults shared with the pipeline top and benches
  localparam int DEFAULT_MEM_LAT    = 1;
  localparam int DEFAULT_STARVE_MAX = 4;

  // starve counter width covers the full legal STARVE_MAX range (1..15)
  localparam int STARVE_W = 4;

  // Which requester owns the memory port this cycle
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_M0   = 2'd1,
    SEL_M1   = 2'd2
  } sel_e;

  // Increment that sticks at the limit instead of wrapping
  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    sat_inc = (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/rsp_tag_pipe.sv
// rtl/rsp_tag_pipe.sv - {valid,id} shift register that tracks outstanding reads
module rsp_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int ID_W  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  input  logic [ID_W-1:0] in_id_i,
  output logic            out_valid_o,
  output logic [ID_W-1:0] out_id_o
);

  logic [DEPTH-1:0] valid_q;
  logic [ID_W-1:0]  id_q [DEPTH];

  // Advance every stage each cycle; async clear drops every in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
      end
    end else begin
      valid_q[0] <= in_valid_i;
      id_q[0]    <= in_id_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        id_q[i]    <= id_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_id_o    = id_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester arbiter for the single-port synchronous data memory
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEFAULT_MEM_LAT,
  parameter int STARVE_MAX = DEFAULT_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  // m0: pipeline MEM stage
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_be,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  // m1: debug / loader
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_be,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  // memory side
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int                BE_W       = DATA_W / 8;
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  sel_e                sel;
  logic [STARVE_W-1:0] starve_cnt_q;
  logic [STARVE_W-1:0] starve_cnt_d;
  logic                tag_in_valid;
  logic                tag_in_id;
  logic                tag_out_valid;
  logic                tag_out_id;

  // Fixed m0 priority, except m1 takes the port once m0 has won STARVE_MAX times in a row
  always_comb begin
    sel = SEL_NONE;
    if (rst_n) begin
      if (m1_req && (!m0_req || starve_cnt_q == STARVE_LIM)) begin
        sel = SEL_M1;
      end else if (m0_req) begin
        sel = SEL_M0;
      end
    end
  end

  assign m0_gnt = (sel == SEL_M0);
  assign m1_gnt = (sel == SEL_M1);
  assign mem_en = m0_gnt | m1_gnt;

  // Route the winning request to memory; reads always enable every byte, idle drives zero
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    case (sel)
      SEL_M0: begin
        mem_we    = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_be    = m0_we ? m0_be : {BE_W{1'b1}};
      end
      SEL_M1: begin
        mem_we    = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_be    = m1_we ? m1_be : {BE_W{1'b1}};
      end
      default: begin
        mem_we = 1'b0;
      end
    endcase
  end

  // Count m0 wins while m1 waits; any m1 service or m1 going idle clears the count
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req || m1_gnt) begin
      starve_cnt_d = '0;
    end else if (m0_gnt) begin
      starve_cnt_d = sat_inc(starve_cnt_q, STARVE_LIM);
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Only reads enter the tag pipe; writes finish on their grant cycle
  assign tag_in_valid = mem_en & ~mem_we;
  assign tag_in_id    = m1_gnt ? ID_DBG : ID_CORE;

  rsp_tag_pipe #(
    .DEPTH (MEM_LAT),
    .ID_W  (1)
  ) u_tag_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (tag_in_valid),
    .in_id_i     (tag_in_id),
    .out_valid_o (tag_out_valid),
    .out_id_o    (tag_out_id)
  );

  // Memory data is shared; the tag at the last stage says whose read it is
  assign m0_rvalid = rst_n & tag_out_valid & (tag_out_id == ID_CORE);
  assign m1_rvalid = rst_n & tag_out_valid & (tag_out_id == ID_DBG);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - scoreboard bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst_n;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic [BE_W-1:0]   m0_be, m1_be;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_rdata;

  dmem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dmem with MEM_LAT read latency; unwritten words read as zero
  logic [31:0] dmem [int];
  logic [31:0] rd_pipe [MEM_LAT];
  initial for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;

  always @(posedge clk) begin
    logic [31:0] w;
    if (mem_en && mem_we) begin
      w = dmem.exists(int'(mem_addr)) ? dmem[int'(mem_addr)] : 32'h0;
      for (int b = 0; b < BE_W; b++)
        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
      dmem[int'(mem_addr)] = w;
    end
    if (mem_en && !mem_we)
      rd_pipe[0] <= dmem.exists(int'(mem_addr)) ? dmem[int'(mem_addr)] : 32'h0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // Reference model: word store, expected response queue, m1 waiting count
  typedef struct {
    logic        id;
    logic [31:0] data;
    int          due;
  } rsp_t;

  logic [31:0] ref_mem [int];
  rsp_t        exp_q [$];
  rsp_t        h;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  int          m0_wins_while_m1_waits = 0;
  bit          log_en = 0;
  bit          gnt_log [$];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 32'h0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: checks every cycle at the falling edge, pushes expected read responses on grant
  always @(negedge clk) begin
    logic        exp_g0, exp_g1, exp_r0, exp_r1, w_we;
    logic [31:0] w_addr, w_data, nw;
    logic [3:0]  w_be;
    cyc++;
    if (!rst_n) begin
      check("rst_m0_gnt", m0_gnt, 0);
      check("rst_m1_gnt", m1_gnt, 0);
      check("rst_m0_rvalid", m0_rvalid, 0);
      check("rst_m1_rvalid", m1_rvalid, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      exp_q.delete();
      m0_wins_while_m1_waits = 0;
    end else begin
      exp_r0 = 0;
      exp_r1 = 0;
      h.data = '0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        h = exp_q.pop_front();
        if (h.id) exp_r1 = 1; else exp_r0 = 1;
      end
      check("m0_rvalid", m0_rvalid, exp_r0);
      check("m1_rvalid", m1_rvalid, exp_r1);
      if (exp_r0) check("m0_rdata", m0_rdata, h.data);
      if (exp_r1) check("m1_rdata", m1_rdata, h.data);

      exp_g1 = m1_req && (!m0_req || m0_wins_while_m1_waits == STARVE_MAX);
      exp_g0 = m0_req && !exp_g1;
      check("m0_gnt", m0_gnt, exp_g0);
      check("m1_gnt", m1_gnt, exp_g1);
      check("mem_en", mem_en, exp_g0 | exp_g1);

      w_we = 0; w_addr = 0; w_data = 0; w_be = 0;
      if (exp_g0) begin
        w_we = m0_we; w_addr = m0_addr; w_data = m0_wdata; w_be = m0_we ? m0_be : 4'hF;
      end else if (exp_g1) begin
        w_we = m1_we; w_addr = m1_addr; w_data = m1_wdata; w_be = m1_we ? m1_be : 4'hF;
      end
      check("mem_we", mem_we, w_we);
      check("mem_addr", mem_addr, w_addr);
      check("mem_wdata", mem_wdata, w_data);
      check("mem_be", mem_be, w_be);

      if (exp_g0 || exp_g1) begin
        if (w_we) begin
          nw = ref_read(w_addr);
          for (int b = 0; b < 4; b++) if (w_be[b]) nw[8*b +: 8] = w_data[8*b +: 8];
          ref_mem[int'(w_addr)] = nw;
        end else begin
          exp_q.push_back('{id: exp_g1, data: ref_read(w_addr), due: cyc + MEM_LAT});
        end
        if (log_en) gnt_log.push_back(exp_g1);
      end

      if (m1_req && exp_g0)
        m0_wins_while_m1_waits = (m0_wins_while_m1_waits < STARVE_MAX) ?
                                 m0_wins_while_m1_waits + 1 : STARVE_MAX;
      else
        m0_wins_while_m1_waits = 0;
    end
  end

  // Hold a request until granted, then release it right after the grant edge
  task automatic issue(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    int n = 0;
    bit got = 0;
    if (port) begin
      m1_we = we; m1_addr = addr; m1_wdata = data; m1_be = be; m1_req = 1;
    end else begin
      m0_we = we; m0_addr = addr; m0_wdata = data; m0_be = be; m0_req = 1;
    end
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      got = port ? m1_gnt : m0_gnt;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: port %0d got no grant in %0d cycles, required a grant", port, n);
    end
    @(posedge clk);
    #1;
    if (port) m1_req = 0; else m0_req = 0;
  endtask

  task automatic random_traffic(input bit port, input int count);
    for (int i = 0; i < count; i++) begin
      bit we = bit'($urandom_range(0, 1));
      logic [31:0] addr = 32'd600 + 32'($urandom_range(0, 7)) * 4;
      issue(port, we, addr, $urandom, 4'($urandom_range(1, 15)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;

    // Loader write then read back through m1
    issue(1, 1, 32'd600, 32'hABCDE000, 4'hF);
    issue(1, 0, 32'd600, 32'h0, 4'h0);

    // Back-to-back m0 reads
    issue(1, 1, 32'd604, 32'd4100, 4'hF);
    issue(0, 0, 32'd600, 32'h0, 4'h0);
    issue(0, 0, 32'd604, 32'h0, 4'h0);

    // Both requesting continuously: m1 must win every fifth grant
    log_en = 1;
    fork
      for (int i = 0; i < 12; i++) issue(0, 0, 32'd600 + 32'(i % 2) * 4, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++)  issue(1, 0, 32'd604, 32'h0, 4'h0);
    join
    log_en = 0;
    checks++;
    if (gnt_log.size() < 10) begin
      errors++;
      $display("FAIL starve_log_len: got %0d grants, required at least 10", gnt_log.size());
    end else begin
      for (int i = 0; i < 10; i++)
        check($sformatf("starve_pattern[%0d]", i), 32'(gnt_log[i]), 32'((i % 5) == 4));
    end

    // Byte-lane write merge
    issue(0, 1, 32'd612, 32'h11223344, 4'hF);
    issue(0, 1, 32'd612, 32'h00005A00, 4'b0010);
    issue(0, 0, 32'd612, 32'h0, 4'h0);

    // Reset right after a read grant must swallow its response
    issue(0, 0, 32'd604, 32'h0, 4'h0);
    rst_n = 0;
    @(posedge clk);
    #1 rst_n = 1;
    repeat (MEM_LAT + 2) @(posedge clk);
    #1;

    // m1 write followed next cycle by m0 read of the same word
    issue(1, 1, 32'd608, 32'hC0FFEE11, 4'hF);
    issue(0, 0, 32'd608, 32'h0, 4'h0);

    // Concurrent random traffic on both ports
    fork
      random_traffic(0, 120);
      random_traffic(1, 120);
    join

    repeat (MEM_LAT + 3) @(posedge clk);
    @(negedge clk);
    check("drain_outstanding", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
